// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver.
// The master modport is the receiver; the slave modport is the line driver and byte consumer.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rx,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx,
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: synchronizes rx, samples each bit mid-cell and
// hands completed bytes to a valid/ready consumer with frame-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  state_t               state_next;

  logic                 rx_sync_p0;
  logic                 rx_sync_p1;
  logic                 rx_s;

  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;

  logic                 cnt_clr;
  logic                 bit_tick;
  logic                 stop_tick;
  logic                 busy;

  logic [DATA_BITS-1:0] data_p0;
  logic                 vld_p0;
  logic                 frame_err_p0;
  logic                 overrun_p0;

  logic                 stop_good;
  logic                 stop_bad;
  logic                 accept;

  // Synchronizer stage: both flops reset high so reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= bus.rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rx_s = rx_sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt == CNT_HALF) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if ((cnt == CNT_LAST) && (bit_idx == BIT_LAST)) state_next = STOP;
      end
      STOP: begin
        if (cnt == CNT_LAST) state_next = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter restarts on every state change and on every data-bit sample.
  always_comb begin
    busy      = (state != IDLE);
    bit_tick  = (state == DATA) && (cnt == CNT_LAST);
    stop_tick = (state == STOP) && (cnt == CNT_LAST);
    cnt_clr   = (state == IDLE) || (state_next != state) || bit_tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
    end else if (state != DATA) begin
      bit_idx <= '0;
    end else if (bit_tick) begin
      bit_idx <= bit_idx + BIT_W'(1);
    end
  end

  // LSB arrives first, so bits enter at the top and walk down to bit 0.
  always_ff @(posedge clk) begin
    if (bit_tick) begin
      shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

  assign stop_good = stop_tick && rx_s;
  assign stop_bad  = stop_tick && !rx_s;
  assign accept    = !vld_p0 || bus.rx_ready;

  // Delivery stage: result registers update the cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0      <= '0;
      vld_p0       <= 1'b0;
      frame_err_p0 <= 1'b0;
      overrun_p0   <= 1'b0;
    end else begin
      frame_err_p0 <= stop_bad;
      overrun_p0   <= stop_good && !accept;
      if (stop_good && accept) begin
        data_p0 <= shreg;
        vld_p0  <= 1'b1;
      end else if (vld_p0 && bus.rx_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = data_p0;
  assign bus.rx_valid  = vld_p0;
  assign bus.frame_err = frame_err_p0;
  assign bus.overrun   = overrun_p0;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx with a byte-queue reference model.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int LAT = CPB / 2 + (DB + 1) * CPB + 1;

  logic clk;
  logic rst;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Observation log, sampled 1 time unit after each rising edge.
  int         cyc      = 0;
  int         got_n    = 0;
  int         last_cyc = 0;
  int         vhi_cnt  = 0;
  int         fe_cnt   = 0;
  int         fe_cyc   = 0;
  int         ov_cnt   = 0;
  int         both_cnt = 0;
  logic       prev_v   = 1'b0;
  logic [7:0] prev_d   = 8'h00;
  logic [7:0] got_q[$];

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (bus.rx_valid) vhi_cnt = vhi_cnt + 1;
    if (bus.rx_valid && (!prev_v || bus.rx_data != prev_d)) begin
      got_q.push_back(bus.rx_data);
      got_n    = got_n + 1;
      last_cyc = cyc;
    end
    if (bus.frame_err) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    if (bus.overrun) ov_cnt = ov_cnt + 1;
    if (bus.frame_err && bus.overrun) both_cnt = both_cnt + 1;
    prev_v = bus.rx_valid;
    prev_d = bus.rx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot = n_tot + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      bus.rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int         c0;
    int         g0;
    int         v0;
    int         f0;
    int         o0;
    int         nfe;
    int         gap;
    logic       bad;
    logic       busy_seen;
    logic [7:0] d;
    logic [7:0] exp_q[$];

    rst          = 1'b1;
    bus.rx       = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.rx_valid, 1'b0);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_overrun", bus.overrun, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    idle(10);

    // 1: clean 0xA5 frame, exact delivery latency
    c0 = cyc; g0 = got_n; v0 = vhi_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("t1_count", got_n - g0, 1);
    chk("t1_data", got_q[g0], 8'hA5);
    chk("t1_latency", last_cyc - c0, LAT + 2);
    chk("t1_valid_cycles", vhi_cnt - v0, 1);
    chk("t1_frame_err", fe_cnt - f0, 0);
    chk("t1_overrun", ov_cnt - o0, 0);
    chk("t1_busy", bus.busy, 1'b0);

    // 2: 4-cycle glitch rejected at the half-bit sample
    g0 = got_n; f0 = fe_cnt;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("t2_busy_start", bus.busy, 1'b1);
    @(negedge clk);
    chk("t2_busy_idle", bus.busy, 1'b0);
    idle(10);
    chk("t2_no_valid", got_n - g0, 0);
    chk("t2_no_frame_err", fe_cnt - f0, 0);
    send_frame(8'h3C, 1'b1);
    idle(20);
    chk("t2_count", got_n - g0, 1);
    chk("t2_data", got_q[g0], 8'h3C);

    // 3: stop bit low, line held low (break)
    c0 = cyc; g0 = got_n; f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    chk("t3_frame_err_pulses", fe_cnt - f0, 1);
    chk("t3_frame_err_time", fe_cyc - c0, LAT + 2);
    chk("t3_no_valid", got_n - g0, 0);
    chk("t3_valid", bus.rx_valid, 1'b0);
    chk("t3_busy_held", bus.busy, 1'b1);
    idle(4);
    chk("t3_busy_release", bus.busy, 1'b0);
    idle(10);
    send_frame(8'h81, 1'b1);
    idle(20);
    chk("t3_count", got_n - g0, 1);
    chk("t3_data", got_q[g0], 8'h81);

    // 4: consumer stalled, second frame overruns
    bus.rx_ready = 1'b0;
    g0 = got_n; o0 = ov_cnt; f0 = fe_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(20);
    chk("t4_valid", bus.rx_valid, 1'b1);
    chk("t4_data", bus.rx_data, 8'h12);
    chk("t4_overrun_pulses", ov_cnt - o0, 1);
    chk("t4_count", got_n - g0, 1);
    chk("t4_frame_err", fe_cnt - f0, 0);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    chk("t4_valid_drop", bus.rx_valid, 1'b0);

    // 5: ready pulsed exactly in the delivery cycle of the second byte
    send_frame(8'h00, 1'b1);
    idle(20);
    chk("t5_first_valid", bus.rx_valid, 1'b1);
    chk("t5_first_data", bus.rx_data, 8'h00);
    c0 = cyc; g0 = got_n; o0 = ov_cnt; v0 = vhi_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (LAT + 1) @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
      end
    join
    idle(20);
    chk("t5_overrun", ov_cnt - o0, 0);
    chk("t5_data", bus.rx_data, 8'hFF);
    chk("t5_valid", bus.rx_valid, 1'b1);
    chk("t5_valid_held", vhi_cnt - v0, cyc - c0);
    chk("t5_count", got_n - g0, 1);

    // 6: reset in the middle of the data bits of 0x77
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("t6_busy_mid", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", bus.rx_valid, 1'b0);
    chk("t6_data", bus.rx_data, 8'h00);
    chk("t6_frame_err", bus.frame_err, 1'b0);
    chk("t6_overrun", bus.overrun, 1'b0);
    chk("t6_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.rx_ready = 1'b1;
    g0 = got_n; f0 = fe_cnt;
    busy_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | bus.busy;
    end
    chk("t6_no_false_start", busy_seen, 1'b0);
    idle(20);
    send_frame(8'h77, 1'b1);
    idle(20);
    chk("t6_count", got_n - g0, 1);
    chk("t6_data_after", got_q[g0], 8'h77);
    chk("t6_no_frame_err", fe_cnt - f0, 0);

    // Randomized frames against the byte-queue model
    g0 = got_n; f0 = fe_cnt; o0 = ov_cnt;
    nfe = 0;
    for (int k = 0; k < 14; k++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(d, !bad);
      if (bad) nfe = nfe + 1;
      else     exp_q.push_back(d);
      gap = int'($urandom_range(0, 30));
      if (bad && gap < 4) gap = 4;
      idle(gap);
    end
    idle(50);
    chk("rnd_count", got_n - g0, exp_q.size());
    chk("rnd_frame_err", fe_cnt - f0, nfe);
    chk("rnd_overrun", ov_cnt - o0, 0);
    for (int i = 0; i < exp_q.size() && (g0 + i) < got_q.size(); i++) begin
      chk($sformatf("rnd_data%0d", i), got_q[g0 + i], exp_q[i]);
    end

    chk("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
